// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: funct3 encodings, FSM states and the pure
// byte-lane helpers used for store steering and load extension.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_lane_t;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  a,
                                                input logic [2:0]  f3);
        logic [31:0] shifted;
        logic [31:0] ext;
        shifted = word >> {a, 3'b000};
        case (f3)
            F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ext = {24'h0, shifted[7:0]};
            F3_HU:   ext = {16'h0, shifted[15:0]};
            default: ext = word;
        endcase
        return ext;
    endfunction

    function automatic store_lane_t store_steer(input logic [31:0] data,
                                                input logic [1:0]  a,
                                                input logic [2:0]  f3);
        store_lane_t s;
        case (f3[1:0])
            2'b00: begin
                s.be    = 4'b0001 << a;
                s.wdata = {4{data[7:0]}};
            end
            2'b01: begin
                s.be    = 4'b0011 << a;
                s.wdata = {2{data[15:0]}};
            end
            default: begin
                s.be    = 4'b1111;
                s.wdata = data;
            end
        endcase
        return s;
    endfunction

    function automatic logic access_legal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
        logic ok;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~a[0];
            F3_W:        ok = (a == 2'b00);
            default:     ok = 1'b0;
        endcase
        // Stores have no unsigned forms, and a simultaneous read+write is undefined.
        if ((rd & wr) | (wr & f3[2]))
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Combinational byte-lane steering for stores and extension for loads,
// plus the alignment/encoding legality check for the current access.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        legal
);

    store_lane_t lane;

    assign lane      = store_steer(store_data, addr_lo, funct3);
    assign be        = lane.be;
    assign wdata     = lane.wdata;
    assign load_data = load_extend(rdata, addr_lo, funct3);
    assign legal     = access_legal(mem_read, mem_write, funct3, addr_lo);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over a req/ready handshake, stalls the
// pipeline until completion or timeout, and buffers the extended load data.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Valid_i,
    input  logic [31:0] ALU_Res_i,
    input  logic [31:0] Store_Data_i,
    input  logic [4:0]  RdAddr_i,
    input  logic [2:0]  Funct3_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        MemToReg_i,
    input  logic        RegWrite_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] ALU_Res_o,
    output logic [31:0] Read_Data_o,
    output logic [4:0]  RdAddr_o,
    output logic        MemToReg_o,
    output logic        RegWrite_o,
    output logic        exc_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rbuf_q;
    logic              exc_q;
    logic [31:0]       load_data;
    logic              legal;
    logic              memop, start, illegal, ready_hit, timeout_hit;

    mem_lane_align u_align (
        .addr_lo    (ALU_Res_i[1:0]),
        .funct3     (Funct3_i),
        .mem_read   (MemRead_i),
        .mem_write  (MemWrite_i),
        .store_data (Store_Data_i),
        .rdata      (dmem_rdata_i),
        .be         (dmem_be_o),
        .wdata      (dmem_wdata_o),
        .load_data  (load_data),
        .legal      (legal)
    );

    assign memop       = Valid_i & (MemRead_i | MemWrite_i);
    assign start       = (state_q == IDLE) & memop & legal;
    assign illegal     = (state_q == IDLE) & memop & ~legal;
    assign ready_hit   = (state_q == REQ) & dmem_ready_i;
    assign timeout_hit = (state_q == REQ) & ~dmem_ready_i & (cnt_q == CNT_LAST);

    assign dmem_req_o  = req_q;
    assign dmem_we_o   = req_q & MemWrite_i;
    assign dmem_addr_o = {ALU_Res_i[31:2], 2'b00};
    assign ALU_Res_o   = ALU_Res_i;
    assign RdAddr_o    = RdAddr_i;
    assign MemToReg_o  = MemToReg_i;
    assign Read_Data_o = rbuf_q;
    assign exc_o       = exc_q;

    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        RegWrite_o = RegWrite_i & Valid_i;
        unique case (state_q)
            IDLE: begin
                if (memop) begin
                    RegWrite_o = 1'b0;
                    if (legal) begin
                        stall_o = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_o    = 1'b1;
                RegWrite_o = 1'b0;
                if (ready_hit | timeout_hit)
                    state_d = DONE;
            end
            DONE: begin
                // exc_q can only be set here by a timeout, so it suppresses the write.
                if (exc_q)
                    RegWrite_o = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exc_q   <= illegal | timeout_hit;
            if (start) begin
                req_q <= 1'b1;
                cnt_q <= '0;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (ready_hit | timeout_hit)
                    req_q <= 1'b0;
            end
            if (ready_hit & MemRead_i)
                rbuf_q <= load_data;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scoreboarded loads/stores against
// a handshake-driven memory, plus passthrough, illegal, timeout and reset cases.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        Valid_i, MemRead_i, MemWrite_i, MemToReg_i, RegWrite_i;
    logic [31:0] ALU_Res_i, Store_Data_i;
    logic [4:0]  RdAddr_i;
    logic [2:0]  Funct3_i;
    logic        dmem_req_o, dmem_we_o, dmem_ready_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_be_o;
    logic        stall_o, MemToReg_o, RegWrite_o, exc_o;
    logic [31:0] ALU_Res_o, Read_Data_o;
    logic [4:0]  RdAddr_o;

    typedef struct packed {
        logic [31:0] read_data;
        logic        reg_write;
        logic [4:0]  rd;
        logic        exc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_read = 32'h0;

    always #5 clk_i = ~clk_i;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .Valid_i(Valid_i), .ALU_Res_i(ALU_Res_i),
        .Store_Data_i(Store_Data_i), .RdAddr_i(RdAddr_i), .Funct3_i(Funct3_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemToReg_i(MemToReg_i),
        .RegWrite_i(RegWrite_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
        .ALU_Res_o(ALU_Res_o), .Read_Data_o(Read_Data_o), .RdAddr_o(RdAddr_o),
        .MemToReg_o(MemToReg_o), .RegWrite_o(RegWrite_o), .exc_o(exc_o)
    );

    task automatic bubble();
        Valid_i = 0; MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; MemToReg_i = 0;
        dmem_ready_i = 0;
    endtask

    // Drives one access, answers the request after ready_at REQ cycles (0 = never),
    // and pops/compares the scoreboard entry when the stage releases the stall.
    task automatic drive_access(input logic is_load, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [4:0] rd, input logic [31:0] mem_word,
                                input int ready_at, output int stall_n, output int req_n,
                                output logic [3:0] be, output logic [31:0] wdata,
                                output logic we, output logic [31:0] baddr);
        exp_t e;
        bit   done = 0;
        stall_n = 0; req_n = 0; be = '0; wdata = '0; we = 0; baddr = '0;
        @(negedge clk_i);
        Valid_i = 1; MemRead_i = is_load; MemWrite_i = ~is_load; Funct3_i = f3;
        ALU_Res_i = addr; Store_Data_i = sdata; RdAddr_i = rd;
        RegWrite_i = is_load; MemToReg_i = is_load; dmem_ready_i = 0;
        for (int cyc = 0; cyc < 32 && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk_i);
                dmem_ready_i = 0;
            end
            #1;
            if (stall_o) stall_n++;
            if (dmem_req_o) begin
                req_n++;
                if (req_n == 1) begin
                    be = dmem_be_o; wdata = dmem_wdata_o; we = dmem_we_o; baddr = dmem_addr_o;
                end
                if (req_n == ready_at) begin
                    dmem_ready_i = 1;
                    dmem_rdata_i = mem_word;
                end
            end
            if (!stall_o) begin
                done = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: output produced with no expectation");
                end else begin
                    e = exp_q.pop_front();
                    if (Read_Data_o !== e.read_data || RegWrite_o !== e.reg_write ||
                        RdAddr_o !== e.rd || exc_o !== e.exc) begin
                        errors++;
                        $display("FAIL done_outputs: got rdata=%h we=%b rd=%0d exc=%b, want rdata=%h we=%b rd=%0d exc=%b",
                                 Read_Data_o, RegWrite_o, RdAddr_o, exc_o,
                                 e.read_data, e.reg_write, e.rd, e.exc);
                    end
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_done: stall never released within 32 cycles");
        end
        @(negedge clk_i);
        bubble();
    endtask

    task automatic test_reset();
        bubble();
        Funct3_i = F3_W; ALU_Res_i = 0; Store_Data_i = 0; RdAddr_i = 0; dmem_rdata_i = 0;
        rst_i = 1;
        #12;
        checks++;
        if (dmem_req_o !== 0 || exc_o !== 0 || Read_Data_o !== 32'h0 || stall_o !== 0) begin
            errors++;
            $display("FAIL reset_state: req=%b exc=%b rdata=%h stall=%b, want 0 0 0 0",
                     dmem_req_o, exc_o, Read_Data_o, stall_o);
        end
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic test_passthrough();
        bit req_seen = 0;
        @(negedge clk_i);
        Valid_i = 1; RegWrite_i = 1; MemToReg_i = 0; RdAddr_i = 5; ALU_Res_i = 32'h1234;
        #1;
        checks++;
        if (stall_o !== 0 || RegWrite_o !== 1 || RdAddr_o !== 5 || ALU_Res_o !== 32'h1234 ||
            MemToReg_o !== 0) begin
            errors++;
            $display("FAIL alu_passthrough: stall=%b we=%b rd=%0d alu=%h m2r=%b, want 0 1 5 1234 0",
                     stall_o, RegWrite_o, RdAddr_o, ALU_Res_o, MemToReg_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            if (dmem_req_o) req_seen = 1;
        end
        checks++;
        if (req_seen) begin
            errors++;
            $display("FAIL alu_no_request: dmem_req_o=1 seen, want 0");
        end
        @(negedge clk_i);
        Valid_i = 0; MemToReg_i = 1;
        #1;
        checks++;
        if (RegWrite_o !== 0 || MemToReg_o !== 1) begin
            errors++;
            $display("FAIL invalid_no_write: we=%b m2r=%b, want 0 1", RegWrite_o, MemToReg_o);
        end
        bubble();
    endtask

    task automatic test_lw();
        int s, r; logic [3:0] be; logic [31:0] wd, ba; logic we;
        exp_q.push_back('{32'hDEADBEEF, 1'b1, 5'd7, 1'b0});
        drive_access(1, F3_W, 32'h100, 0, 7, 32'hDEADBEEF, 3, s, r, be, wd, we, ba);
        last_read = 32'hDEADBEEF;
        checks++;
        if (s != 4 || r != 3) begin
            errors++;
            $display("FAIL lw_latency: stall=%0d req=%0d, want 4 3", s, r);
        end
        checks++;
        if (be !== 4'b1111 || we !== 0 || ba !== 32'h100) begin
            errors++;
            $display("FAIL lw_bus: be=%b we=%b addr=%h, want 1111 0 00000100", be, we, ba);
        end
    endtask

    task automatic test_narrow_loads();
        logic [2:0]  f3s[5]   = '{F3_B, F3_BU, F3_H, F3_HU, F3_H};
        logic [31:0] addrs[5] = '{32'h103, 32'h103, 32'h102, 32'h200, 32'h200};
        logic [31:0] words[5] = '{32'h80000000, 32'h80000000, 32'h80017F00, 32'h1234F00D, 32'h1234F00D};
        logic [31:0] exps[5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'hFFFFF00D};
        int s, r; logic [3:0] be; logic [31:0] wd, ba; logic we;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{exps[i], 1'b1, 5'(i + 10), 1'b0});
            drive_access(1, f3s[i], addrs[i], 0, 5'(i + 10), words[i], 1, s, r, be, wd, we, ba);
            last_read = exps[i];
            checks++;
            if (s != 2 || r != 1) begin
                errors++;
                $display("FAIL narrow_latency[%0d]: stall=%0d req=%0d, want 2 1", i, s, r);
            end
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3s[3]   = '{F3_H, F3_B, F3_W};
        logic [31:0] addrs[3] = '{32'h102, 32'h101, 32'h104};
        logic [31:0] data[3]  = '{32'h0000ABCD, 32'h12345677, 32'hCAFEF00D};
        logic [3:0]  ebe[3]   = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ewd[3]   = '{32'hABCDABCD, 32'h77777777, 32'hCAFEF00D};
        logic [31:0] eaddr[3] = '{32'h100, 32'h100, 32'h104};
        int s, r; logic [3:0] be; logic [31:0] wd, ba; logic we;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{last_read, 1'b0, 5'd3, 1'b0});
            drive_access(0, f3s[i], addrs[i], data[i], 3, 32'hFFFFFFFF, 2, s, r, be, wd, we, ba);
            checks++;
            if (we !== 1 || be !== ebe[i] || wd !== ewd[i] || ba !== eaddr[i]) begin
                errors++;
                $display("FAIL store_bus[%0d]: we=%b be=%b wdata=%h addr=%h, want 1 %b %h %h",
                         i, we, be, wd, ba, ebe[i], ewd[i], eaddr[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic        rds[6]   = '{1, 1, 0, 1, 0, 1};
        logic        wrs[6]   = '{0, 0, 1, 0, 1, 1};
        logic [2:0]  f3s[6]   = '{F3_W, F3_H, F3_W, 3'b011, F3_BU, F3_B};
        logic [31:0] addrs[6] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            Valid_i = 1; MemRead_i = rds[i]; MemWrite_i = wrs[i]; Funct3_i = f3s[i];
            ALU_Res_i = addrs[i]; RegWrite_i = 1; RdAddr_i = 9;
            #1;
            checks++;
            if (stall_o !== 0 || dmem_req_o !== 0 || RegWrite_o !== 0) begin
                errors++;
                $display("FAIL illegal_issue[%0d]: stall=%b req=%b we=%b, want 0 0 0",
                         i, stall_o, dmem_req_o, RegWrite_o);
            end
            @(negedge clk_i);
            bubble();
            #1;
            checks++;
            if (exc_o !== 1 || dmem_req_o !== 0) begin
                errors++;
                $display("FAIL illegal_exc[%0d]: exc=%b req=%b, want 1 0", i, exc_o, dmem_req_o);
            end
            @(negedge clk_i);
            #1;
            checks++;
            if (exc_o !== 0) begin
                errors++;
                $display("FAIL illegal_pulse[%0d]: exc=%b, want 0", i, exc_o);
            end
        end
    endtask

    task automatic test_timeout();
        int s, r; logic [3:0] be; logic [31:0] wd, ba; logic we;
        exp_q.push_back('{last_read, 1'b0, 5'd12, 1'b1});
        drive_access(1, F3_W, 32'h300, 0, 12, 32'h0, 0, s, r, be, wd, we, ba);
        checks++;
        if (r != 4 || s != 5) begin
            errors++;
            $display("FAIL timeout_len: req=%0d stall=%0d, want 4 5", r, s);
        end
        #1;
        checks++;
        if (exc_o !== 0 || dmem_req_o !== 0) begin
            errors++;
            $display("FAIL timeout_after: exc=%b req=%b, want 0 0", exc_o, dmem_req_o);
        end
    endtask

    task automatic test_reset_mid_req();
        int wait_n = 0;
        @(negedge clk_i);
        Valid_i = 1; MemRead_i = 1; Funct3_i = F3_W; ALU_Res_i = 32'h400; RegWrite_i = 1; RdAddr_i = 4;
        while (!dmem_req_o && wait_n < 10) begin
            @(negedge clk_i);
            wait_n++;
        end
        @(negedge clk_i);
        #1;
        rst_i = 1;
        #1;
        checks++;
        if (dmem_req_o !== 0 || dut.state_q !== IDLE || wait_n >= 10) begin
            errors++;
            $display("FAIL reset_mid_req: req=%b state=%0d waited=%0d, want 0 IDLE <10",
                     dmem_req_o, dut.state_q, wait_n);
        end
        bubble();
        @(negedge clk_i);
        rst_i = 0;
        @(negedge clk_i);
        #1;
        checks++;
        if (RegWrite_o !== 0 || Read_Data_o !== 32'h0 || exc_o !== 0) begin
            errors++;
            $display("FAIL reset_no_write: we=%b rdata=%h exc=%b, want 0 0 0",
                     RegWrite_o, Read_Data_o, exc_o);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lw();
        test_narrow_loads();
        test_stores();
        test_illegal();
        test_timeout();
        test_reset_mid_req();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
